// File: rtl/fetch_buffer_if.sv
// -----------------------------------------------------------------------------
// fetch_buffer_if
//   Groups the fetch-side bundle, the decode-side bundle and the flow-control
//   signals of the fetch buffer. Each IF_ID packet is carried as parallel
//   per-lane fields (valid, inst, PC, NPC, predict_taken), with lane 0 being
//   the oldest instruction.
//   master : fetch/decode side (drives bundle, squash, dispatch_num)
//   slave  : fetch buffer (drives fb_stall, id_* bundle, fb_count)
// -----------------------------------------------------------------------------
interface fetch_buffer_if #(
    parameter int N     = 2,
    parameter int DEPTH = 8
);
    logic                           squash;
    logic [N-1:0]                   if_valid;
    logic [N-1:0][31:0]             if_inst;
    logic [N-1:0][31:0]             if_pc;
    logic [N-1:0][31:0]             if_npc;
    logic [N-1:0]                   if_pt;
    logic [$clog2(N+1)-1:0]         dispatch_num;

    logic                           fb_stall;
    logic [N-1:0]                   id_valid;
    logic [N-1:0][31:0]             id_inst;
    logic [N-1:0][31:0]             id_pc;
    logic [N-1:0][31:0]             id_npc;
    logic [N-1:0]                   id_pt;
    logic [$clog2(DEPTH+1)-1:0]     fb_count;

    modport master (
        output squash, if_valid, if_inst, if_pc, if_npc, if_pt, dispatch_num,
        input  fb_stall, id_valid, id_inst, id_pc, id_npc, id_pt, fb_count
    );

    modport slave (
        input  squash, if_valid, if_inst, if_pc, if_npc, if_pt, dispatch_num,
        output fb_stall, id_valid, id_inst, id_pc, id_npc, id_pt, fb_count
    );
endinterface

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   Instruction queue between fetch and decode. A DEPTH-entry ring absorbs up
//   to N packets per cycle (valid lanes compacted in lane order) and presents
//   the N oldest entries to decode, lane 0 oldest. Stalls fetch when a full
//   bundle might not fit; squash empties the queue on the next edge.
//   Ports:
//     clock  in  rising-edge clock
//     reset  in  asynchronous reset, active low
//     fb     fetch_buffer_if.slave (bundle in, bundle out, stall, count)
// -----------------------------------------------------------------------------
module fetch_buffer #(
    parameter int DEPTH = 8,
    parameter int N     = 2
) (
    input  logic           clock,
    input  logic           reset,
    fetch_buffer_if.slave  fb
);
    localparam int          IW  = $clog2(DEPTH);
    localparam int          PW  = IW + 1;          // pointer with wrap bit
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam int          DW  = $clog2(N + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Ring storage: payload only, never reset (validity comes from r_count).
    logic [31:0]    r_inst [DEPTH];
    logic [31:0]    r_pc   [DEPTH];
    logic [31:0]    r_npc  [DEPTH];
    logic           r_pt   [DEPTH];

    logic [PW-1:0]  r_head, r_tail;
    logic [CW-1:0]  r_count;

    logic                   w_stall, w_accept;
    logic [N-1:0][DW-1:0]   w_slot;
    logic [DW-1:0]          w_vcnt, w_enq, w_avail, w_deq;

    // Stall looks only at registered occupancy: (DEPTH - count) < N.
    assign w_stall  = (r_count > CW'(DEPTH - N));
    assign w_accept = !w_stall && !fb.squash;

    // Prefix count of valid lanes gives each valid lane its offset from tail,
    // which closes any gaps between valid lanes.
    always_comb begin
        w_vcnt = '0;
        for (int i = 0; i < N; i++) begin
            w_slot[i] = w_vcnt;
            if (fb.if_valid[i]) w_vcnt = w_vcnt + DW'(1);
        end
    end

    assign w_enq   = w_accept ? w_vcnt : '0;
    assign w_avail = (r_count < CW'(N)) ? DW'(r_count) : DW'(N);
    // Decode may ask for more than is presented; clamp to what is visible.
    assign w_deq   = (fb.dispatch_num < w_avail) ? fb.dispatch_num : w_avail;

    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (w_accept && fb.if_valid[i]) begin
                logic [PW-1:0] p;
                p = r_tail + PW'(w_slot[i]);
                r_inst[p[IW-1:0]] <= fb.if_inst[i];
                r_pc[p[IW-1:0]]   <= fb.if_pc[i];
                r_npc[p[IW-1:0]]  <= fb.if_npc[i];
                r_pt[p[IW-1:0]]   <= fb.if_pt[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (fb.squash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_deq);
            r_tail  <= r_tail + PW'(w_enq);
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
            assert (r_count <= CW'(DEPTH));
        end
    end

    // Output lanes: entry[head+i] while i < min(count, N), else a NOP bubble.
    always_comb begin
        fb.id_valid = '0;
        fb.id_inst  = '0;
        fb.id_pc    = '0;
        fb.id_npc   = '0;
        fb.id_pt    = '0;
        for (int i = 0; i < N; i++) begin
            logic [PW-1:0] p;
            p = r_head + PW'(i);
            if (DW'(i) < w_avail) begin
                fb.id_valid[i] = 1'b1;
                fb.id_inst[i]  = r_inst[p[IW-1:0]];
                fb.id_pc[i]    = r_pc[p[IW-1:0]];
                fb.id_npc[i]   = r_npc[p[IW-1:0]];
                fb.id_pt[i]    = r_pt[p[IW-1:0]];
            end else begin
                fb.id_inst[i]  = NOP;
            end
        end
    end

    assign fb.fb_stall = w_stall;
    assign fb.fb_count = r_count;
endmodule

// File: tb/tb_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_buffer
//   Directed scenarios followed by random traffic, checked against a queue
//   model of the instruction buffer.
// -----------------------------------------------------------------------------
module tb_fetch_buffer;
    localparam int          N     = 2;
    localparam int          DEPTH = 8;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_buffer_if #(.N(N), .DEPTH(DEPTH)) fbi ();

    fetch_buffer #(.DEPTH(DEPTH), .N(N)) dut (
        .clock (clk),
        .reset (rst_n),
        .fb    (fbi)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        pt;
    } ent_t;

    ent_t q[$];
    int   ntests = 0;
    int   nfail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int n  = q.size();
        int av = (n < N) ? n : N;
        chk("count", 32'(fbi.fb_count), n);
        chk("stall", 32'(fbi.fb_stall), ((DEPTH - n) < N) ? 1 : 0);
        for (int i = 0; i < N; i++) begin
            if (i < av) begin
                chk($sformatf("l%0d_valid", i), 32'(fbi.id_valid[i]), 1);
                chk($sformatf("l%0d_pc", i),    fbi.id_pc[i],   q[i].pc);
                chk($sformatf("l%0d_inst", i),  fbi.id_inst[i], q[i].inst);
                chk($sformatf("l%0d_npc", i),   fbi.id_npc[i],  q[i].npc);
                chk($sformatf("l%0d_pt", i),    32'(fbi.id_pt[i]), 32'(q[i].pt));
            end else begin
                chk($sformatf("l%0d_valid", i), 32'(fbi.id_valid[i]), 0);
                chk($sformatf("l%0d_inst", i),  fbi.id_inst[i], NOP);
                chk($sformatf("l%0d_pc", i),    fbi.id_pc[i],   0);
                chk($sformatf("l%0d_npc", i),   fbi.id_npc[i],  0);
                chk($sformatf("l%0d_pt", i),    32'(fbi.id_pt[i]), 0);
            end
        end
    endtask

    // One clock: drive after the falling edge, check before the rising edge,
    // advance the model at the rising edge, return at the next falling edge.
    task automatic step(input bit sq, input bit [1:0] v,
                        input logic [31:0] pc0, input logic [31:0] pc1,
                        input int dn);
        ent_t e [N];
        int   n, av, deq;
        bit   stall;
        e[0] = '{inst: $urandom, pc: pc0, npc: pc0 + 4, pt: 1'($urandom)};
        e[1] = '{inst: $urandom, pc: pc1, npc: pc1 + 4, pt: 1'($urandom)};
        fbi.squash       = sq;
        fbi.dispatch_num = 2'(dn);
        for (int i = 0; i < N; i++) begin
            fbi.if_valid[i] = v[i];
            fbi.if_inst[i]  = e[i].inst;
            fbi.if_pc[i]    = e[i].pc;
            fbi.if_npc[i]   = e[i].npc;
            fbi.if_pt[i]    = e[i].pt;
        end
        #1;
        check_model();
        @(posedge clk);
        n     = q.size();
        stall = (DEPTH - n) < N;
        if (sq) begin
            q.delete();
        end else begin
            av  = (n < N) ? n : N;
            deq = (dn < av) ? dn : av;
            repeat (deq) void'(q.pop_front());
            if (!stall)
                for (int i = 0; i < N; i++) if (v[i]) q.push_back(e[i]);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) step(1'b0, 2'b00, 32'h0, 32'h0, 0);
    endtask

    initial begin
        int pc;
        rst_n            = 1'b0;
        fbi.squash       = 1'b0;
        fbi.if_valid     = '0;
        fbi.if_inst      = '0;
        fbi.if_pc        = '0;
        fbi.if_npc       = '0;
        fbi.if_pt        = '0;
        fbi.dispatch_num = '0;

        // Reset state and release
        #12;
        chk("rst_count", 32'(fbi.fb_count), 0);
        chk("rst_valid", 32'(fbi.id_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_stall", 32'(fbi.fb_stall), 0);
        @(negedge clk);

        // Mid-cycle asynchronous reset with entries present
        step(1'b0, 2'b11, 32'h500, 32'h504, 0);
        step(1'b0, 2'b11, 32'h508, 32'h50c, 0);
        chk("pre_rst_count", 32'(fbi.fb_count), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(fbi.fb_count), 0);
        chk("async_rst_valid", 32'(fbi.id_valid), 0);
        chk("async_rst_stall", 32'(fbi.fb_stall), 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_stall", 32'(fbi.fb_stall), 0);

        // Fill to DEPTH, then a fifth bundle is ignored
        step(1'b0, 2'b11, 32'd0,  32'd4,  0);
        step(1'b0, 2'b11, 32'd8,  32'd12, 0);
        step(1'b0, 2'b11, 32'd16, 32'd20, 0);
        step(1'b0, 2'b11, 32'd24, 32'd28, 0);
        chk("fill_count", 32'(fbi.fb_count), 8);
        chk("fill_stall", 32'(fbi.fb_stall), 1);
        step(1'b0, 2'b11, 32'd32, 32'd36, 0);
        chk("fill5_count", 32'(fbi.fb_count), 8);
        chk("fill_l0_pc", fbi.id_pc[0], 32'd0);
        chk("fill_l1_pc", fbi.id_pc[1], 32'd4);
        repeat (4) step(1'b0, 2'b00, 32'h0, 32'h0, 2);
        chk("drained", 32'(fbi.fb_count), 0);

        // Gap compaction
        step(1'b0, 2'b01, 32'd40, 32'hdead, 0);
        step(1'b0, 2'b11, 32'd44, 32'd48,   0);
        chk("gap_count", 32'(fbi.fb_count), 3);
        chk("gap_l0_pc", fbi.id_pc[0], 32'd40);
        chk("gap_l1_pc", fbi.id_pc[1], 32'd44);

        // Concurrent enqueue and dequeue
        step(1'b0, 2'b11, 32'd52, 32'd56, 2);
        chk("conc_count", 32'(fbi.fb_count), 3);
        chk("conc_l0_pc", fbi.id_pc[0], 32'd48);
        chk("conc_l1_pc", fbi.id_pc[1], 32'd52);

        // Wrap-around in steady state, then drain with clamp
        pc = 60;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 2'b11, 32'(pc), 32'(pc + 4), 2);
            pc += 8;
        end
        step(1'b0, 2'b00, 32'h0, 32'h0, 2);
        chk("wrap_one_left", 32'(fbi.fb_count), 1);
        step(1'b0, 2'b00, 32'h0, 32'h0, 2);
        chk("clamp_count", 32'(fbi.fb_count), 0);

        // Squash overrides same-cycle enqueue and dequeue
        step(1'b0, 2'b11, 32'd300, 32'd304, 0);
        step(1'b0, 2'b11, 32'd308, 32'd312, 0);
        step(1'b0, 2'b11, 32'd316, 32'd320, 0);
        chk("presq_count", 32'(fbi.fb_count), 6);
        step(1'b1, 2'b11, 32'd400, 32'd404, 2);
        chk("sq_count", 32'(fbi.fb_count), 0);
        chk("sq_valid", 32'(fbi.id_valid), 0);
        chk("sq_stall", 32'(fbi.fb_stall), 0);
        step(1'b0, 2'b01, 32'd100, 32'h0, 0);
        chk("postsq_l0_pc", fbi.id_pc[0], 32'd100);
        chk("postsq_l0_v",  32'(fbi.id_valid[0]), 1);
        idle(1);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            bit sq = ($urandom_range(0, 31) == 0);
            step(sq, 2'($urandom), 32'(pc), 32'(pc + 4), int'($urandom_range(0, 2)));
            pc += 8;
        end
        idle(1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
